rr_arbiter: RTL and testbench

Registered round-robin arbiter that owns the responder side of the `request`/`grant` handshake used by the block-level testbenches. Up to N requesters raise `request` bits. The arbiter returns a one-hot `grant` one clock edge later and holds it until the owner drops its request. It sits between bus masters and a single shared resource; the bench drives `request` and checks `grant`.

---
 rtl/rr_arbiter.sv | 110 +++++++++++
 tb/tb_rr_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter: one-hot grant one edge after request, held until the owner releases.
// Optional hold limit under contention is enabled by defining ARB_HOLD_LIMIT_EN.
module rr_arbiter #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         request,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
);

  localparam int IW = $clog2(N);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic [IW-1:0]   r_grant_id;
  logic            r_busy;
  logic [IW-1:0]   r_ptr;

  logic            w_found;
  logic [IW-1:0]   w_win;
  int              w_idx;
  logic [N-1:0]    w_onehot;
  logic [IW-1:0]   w_ptr_next;
  logic            w_revoke;

  // Scan from the highest offset down so the offset closest to r_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = (int'(r_ptr) + k) % N;
      if (request[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IW-1:0];
      end
    end
  end

  assign w_onehot   = {{(N-1){1'b0}}, 1'b1} << w_win;
  assign w_ptr_next = (r_grant_id == IW'(N - 1)) ? '0 : r_grant_id + 1'b1;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] r_hold;
  logic          w_other;

  // r_hold counts completed grant cycles, so the edge that ends cycle MAX_HOLD sees MAX_HOLD-1.
  assign w_other  = |(request & ~r_grant);
  assign w_revoke = w_other && (r_hold >= HW'(MAX_HOLD - 1));
`else
  logic w_unused_hold;

  assign w_unused_hold = (MAX_HOLD == 0);
  assign w_revoke      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_ptr      <= '0;
`ifdef ARB_HOLD_LIMIT_EN
      r_hold     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant    <= w_onehot;
            r_grant_id <= w_win;
            r_busy     <= 1'b1;
            r_state    <= S_GRANT;
`ifdef ARB_HOLD_LIMIT_EN
            r_hold     <= '0;
`endif
          end
        end
        S_GRANT: begin
          // Release and revocation both pass through IDLE, so handover always has a gap cycle.
          if (!request[r_grant_id] || w_revoke) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_ptr_next;
            r_state <= S_IDLE;
          end else begin
`ifdef ARB_HOLD_LIMIT_EN
            if (r_hold != HW'(MAX_HOLD)) r_hold <= r_hold + 1'b1;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter (N=2, MAX_HOLD=4): directed vector table, hand-written corner sequences,
// and randomized requests checked against a behavioural model of the arbitration rules.
module tb_rr_arbiter;

  localparam int N        = 2;
  localparam int MAX_HOLD = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] request;
  logic [N-1:0] grant;
  logic         grant_id;
  logic         busy;

  rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .request  (request),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state: owner index (-1 = nobody), next-priority pointer, last owner, cycles held.
  int m_owner;
  int m_ptr;
  int m_gid;
  int m_cycles;

  typedef struct {
    logic [1:0] req;
    logic [1:0] g;
    logic       id;
    logic       b;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = 0;
    m_gid    = 0;
    m_cycles = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] req);
    bit found;
    bit other;
    bit revoke;
    int idx;
    if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && req[idx]) begin
          found    = 1;
          m_owner  = idx;
          m_gid    = idx;
          m_cycles = 1;
        end
      end
    end else begin
      other = 0;
      for (int i = 0; i < N; i++)
        if (i != m_owner && req[i]) other = 1;
      revoke = 0;
`ifdef ARB_HOLD_LIMIT_EN
      revoke = other && (m_cycles >= MAX_HOLD);
`endif
      if (!req[m_owner] || revoke) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_cycles++;
      end
    end
  endtask

  task automatic check_model(input string nm);
    logic [N-1:0] eg;
    eg = (m_owner < 0) ? '0 : N'(1 << m_owner);
    check({nm, "_grant"}, 32'(grant), 32'(eg));
    check({nm, "_id"}, 32'(grant_id), 32'(m_gid));
    check({nm, "_busy"}, 32'(busy), 32'(m_owner >= 0));
  endtask

  // Called at a falling edge: drive, let one rising edge happen, return at the next falling edge.
  task automatic step(input logic [N-1:0] req);
    request = req;
    @(posedge clk);
    model_edge(req);
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] rq;

    // Round-robin alternation, non-owner toggling, single requesters and pointer wrap.
    tbl[0]  = '{2'b11, 2'b01, 1'b0, 1'b1};
    tbl[1]  = '{2'b11, 2'b01, 1'b0, 1'b1};
    tbl[2]  = '{2'b11, 2'b01, 1'b0, 1'b1};
    tbl[3]  = '{2'b10, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{2'b11, 2'b10, 1'b1, 1'b1};
    tbl[5]  = '{2'b11, 2'b10, 1'b1, 1'b1};
    tbl[6]  = '{2'b11, 2'b10, 1'b1, 1'b1};
    tbl[7]  = '{2'b01, 2'b00, 1'b1, 1'b0};
    tbl[8]  = '{2'b11, 2'b01, 1'b0, 1'b1};
    tbl[9]  = '{2'b01, 2'b01, 1'b0, 1'b1};
    tbl[10] = '{2'b11, 2'b01, 1'b0, 1'b1};
    tbl[11] = '{2'b10, 2'b00, 1'b0, 1'b0};
    tbl[12] = '{2'b00, 2'b00, 1'b0, 1'b0};
    tbl[13] = '{2'b01, 2'b01, 1'b0, 1'b1};
    tbl[14] = '{2'b00, 2'b00, 1'b0, 1'b0};
    tbl[15] = '{2'b10, 2'b10, 1'b1, 1'b1};
    tbl[16] = '{2'b00, 2'b00, 1'b1, 1'b0};

    model_reset();
    rst     = 1'b0;
    request = '0;

    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_id", 32'(grant_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    #5;
    rst     = 1'b1;
    request = 2'b01;
    @(posedge clk);
    model_edge(2'b01);
    @(negedge clk);
    check("basic_grant", 32'(grant), 32'h1);
    check("basic_id", 32'(grant_id), 32'h0);
    check("basic_busy", 32'(busy), 32'h1);

    step(2'b00);
    check("rel_grant", 32'(grant), 32'h0);
    step(2'b10);
    check("g10_grant", 32'(grant), 32'h2);
    check("g10_id", 32'(grant_id), 32'h1);

    // Reset in the middle of a cycle must clear the grant without waiting for an edge.
    #2;
    rst     = 1'b0;
    request = '0;
    #1;
    check("async_rst_grant", 32'(grant), 32'h0);
    check("async_rst_id", 32'(grant_id), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].req);
      check($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      check($sformatf("tbl%0d_id", i), 32'(grant_id), 32'(tbl[i].id));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].b));
      check_model($sformatf("tbl%0d_model", i));
    end

    // Requester 0 holds; requester 1 joins during grant cycle 2.
    step(2'b01);
    check("hold_c1", 32'(grant), 32'h1);
    step(2'b01);
    check("hold_c2", 32'(grant), 32'h1);
    step(2'b11);
    check("hold_c3", 32'(grant), 32'h1);
    step(2'b11);
    check("hold_c4", 32'(grant), 32'h1);
    check_model("hold_c4_model");
    step(2'b11);
`ifdef ARB_HOLD_LIMIT_EN
    check("hold_revoke", 32'(grant), 32'h0);
`else
    check("hold_keep5", 32'(grant), 32'h1);
`endif
    check_model("hold_c5_model");
    step(2'b11);
`ifdef ARB_HOLD_LIMIT_EN
    check("hold_next", 32'(grant), 32'h2);
`else
    check("hold_keep6", 32'(grant), 32'h1);
`endif
    check_model("hold_c6_model");
    step(2'b00);
    check("hold_release", 32'(grant), 32'h0);

    // Sticky random requests so grants last several cycles and contention is common.
    rq = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom_range(0, (1 << N) - 1));
      step(rq);
      check_model("rand");
      check("rand_busy_or", 32'(busy), 32'(|grant));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
